// File: rtl/spi_byte_rx.sv
// -----------------------------------------------------------------------------
// spi_byte_rx
//
// SPI mode-0 slave receiver (CPOL=0, CPHA=0) that runs entirely in the clk
// domain. SCK, CS_N and MOSI are oversampled through synchronizer chains,
// and edges are detected on the synchronized copies. Bits are assembled
// into bytes and handed to the pixel-stream logic through a one-entry
// valid/ready output register. A one-cycle activity strobe is emitted for
// every completed byte, including bytes dropped because the register was
// full. It feeds the activity-LED pulse stretcher.
//
// Parameters:
//   SYSTEM_CLOCK  clk frequency in Hz (max SCK = SYSTEM_CLOCK/8)
//   SYNC_STAGES   synchronizer depth for the SPI inputs (>= 2)
//   MSB_FIRST     1: first bit received lands in bit 7, 0: lands in bit 0
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   spi_sck      SPI clock (asynchronous)
//   spi_cs_n     SPI chip select, active low (asynchronous)
//   spi_mosi     SPI data in (asynchronous)
//   rx_data      received byte, stable while rx_valid=1
//   rx_valid     rx_data holds an unconsumed byte
//   rx_ready     consumer accepts; pop = rx_valid & rx_ready
//   frame_start  one-cycle pulse on CS_N falling edge
//   frame_end    one-cycle pulse on CS_N rising edge
//   activity     one-cycle pulse per completed byte
//   overrun      sticky: a byte was dropped because rx_valid was set
//   overrun_clr  synchronous clear of overrun (set wins)
// -----------------------------------------------------------------------------
module spi_byte_rx #(
    parameter int SYSTEM_CLOCK = 50000000,
    parameter int SYNC_STAGES  = 2,
    parameter int MSB_FIRST    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_start,
    output logic       frame_end,
    output logic       activity,
    output logic       overrun,
    input  logic       overrun_clr
);

    // Elaboration-time sanity check on the parameters.
    if (SYNC_STAGES < 2 || SYSTEM_CLOCK < 1) begin : g_bad_params
        $error("spi_byte_rx: SYNC_STAGES must be >= 2 and SYSTEM_CLOCK positive");
    end

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Synchronizer chains; bit 0 is the first stage.
    logic [SYNC_STAGES-1:0] sck_sync_q,  sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_hist_q,  sck_hist_d;
    logic                   cs_hist_q,   cs_hist_d;

    logic [0:0] state_q,       state_d;
    logic [2:0] bit_cnt_q,     bit_cnt_d;
    logic [7:0] shift_q,       shift_d;
    logic [7:0] rx_data_q,     rx_data_d;
    logic       rx_valid_q,    rx_valid_d;
    logic       frame_start_q, frame_start_d;
    logic       frame_end_q,   frame_end_d;
    logic       activity_q,    activity_d;
    logic       overrun_q,     overrun_d;

    logic       sck_s, cs_s, mosi_s;
    logic       sck_rise, cs_fall, cs_rise;
    logic [7:0] shift_in;
    logic       byte_done;
    logic       pop;
    logic       load;

    // MOSI goes through the same depth as SCK, so the bit seen at the last
    // stage is the one that was on the pin when the detected SCK edge was.
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  spi_sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sck_s       = sck_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sck_hist_d  = sck_s;
        cs_hist_d   = cs_s;
        sck_rise    = sck_s & ~sck_hist_q;
        cs_fall     = ~cs_s & cs_hist_q;
        cs_rise     = cs_s & ~cs_hist_q;
        shift_in    = (MSB_FIRST != 0) ? {shift_q[6:0], mosi_s}
                                       : {mosi_s, shift_q[7:1]};
    end

    // Frame FSM and bit assembly. A CS_N rise wins over a coincident SCK
    // rise, so a bit arriving with the deselect is never sampled and any
    // partial byte is thrown away.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        byte_done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    frame_start_d = 1'b1;
                    bit_cnt_d     = 3'd0;
                    shift_d       = 8'd0;
                    state_d       = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    frame_end_d = 1'b1;
                    bit_cnt_d   = 3'd0;
                    state_d     = ST_IDLE;
                end else if (sck_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    byte_done = (bit_cnt_q == 3'd7);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = 3'd0;
            end
        endcase
    end

    // One-entry output register. A pop in the completion cycle frees the
    // slot, so the new byte loads and rx_valid simply stays high. Without
    // room the byte is dropped and the sticky overrun flag is set.
    always_comb begin
        pop        = rx_valid_q & rx_ready;
        load       = byte_done & (~rx_valid_q | pop);
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        activity_d = byte_done;
        if (load) begin
            rx_data_d  = shift_in;
            rx_valid_d = 1'b1;
        end else if (pop) begin
            rx_valid_d = 1'b0;
        end
        if (byte_done && !load) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // State registers; synchronizers reset to the idle bus levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q    <= '0;
            cs_sync_q     <= '1;
            mosi_sync_q   <= '0;
            sck_hist_q    <= 1'b0;
            cs_hist_q     <= 1'b1;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            rx_data_q     <= 8'd0;
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            activity_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sck_sync_q    <= sck_sync_d;
            cs_sync_q     <= cs_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sck_hist_q    <= sck_hist_d;
            cs_hist_q     <= cs_hist_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            activity_q    <= activity_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign activity    = activity_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_spi_byte_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_byte_rx
//
// Directed bench for spi_byte_rx. Two instances share one SPI bus: dutMsb
// (MSB_FIRST=1) and dutLsb (MSB_FIRST=0), each with its own consumer side.
// SCK runs at clk/8 (4 clk cycles high, 4 low); bus signals change on the
// falling clk edge and outputs are observed on the falling clk edge.
// -----------------------------------------------------------------------------
module tb_spi_byte_rx;

   logic       clk;
   logic       resetN;
   logic       spiSck;
   logic       spiCsN;
   logic       spiMosi;

   logic [7:0] rxData;
   logic       rxValid;
   logic       rxReady;
   logic       frameStart;
   logic       frameEnd;
   logic       activity;
   logic       overrun;
   logic       overrunClr;

   logic [7:0] rxDataL;
   logic       rxValidL;
   logic       rxReadyL;
   logic       frameStartL;
   logic       frameEndL;
   logic       activityL;
   logic       overrunL;

   int         totalChecks;
   int         badChecks;

   // Event counters kept by the monitor; tests look at deltas.
   int         activityCount;
   int         frameStartCount;
   int         frameEndCount;
   int         validCycles;
   int         popCountL;
   logic [7:0] popQ[$];

   spi_byte_rx #(
      .SYSTEM_CLOCK(50000000),
      .SYNC_STAGES (2),
      .MSB_FIRST   (1)
   ) dutMsb (
      .clk        (clk),
      .reset_n    (resetN),
      .spi_sck    (spiSck),
      .spi_cs_n   (spiCsN),
      .spi_mosi   (spiMosi),
      .rx_data    (rxData),
      .rx_valid   (rxValid),
      .rx_ready   (rxReady),
      .frame_start(frameStart),
      .frame_end  (frameEnd),
      .activity   (activity),
      .overrun    (overrun),
      .overrun_clr(overrunClr)
   );

   spi_byte_rx #(
      .SYSTEM_CLOCK(50000000),
      .SYNC_STAGES (2),
      .MSB_FIRST   (0)
   ) dutLsb (
      .clk        (clk),
      .reset_n    (resetN),
      .spi_sck    (spiSck),
      .spi_cs_n   (spiCsN),
      .spi_mosi   (spiMosi),
      .rx_data    (rxDataL),
      .rx_valid   (rxValidL),
      .rx_ready   (rxReadyL),
      .frame_start(frameStartL),
      .frame_end  (frameEndL),
      .activity   (activityL),
      .overrun    (overrunL),
      .overrun_clr(1'b0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: a pop happens at the next rising edge when valid & ready are
   // both high here.
   always @(negedge clk) begin
      if (activity)   activityCount++;
      if (frameStart) frameStartCount++;
      if (frameEnd)   frameEndCount++;
      if (rxValid)    validCycles++;
      if (rxValid && rxReady) popQ.push_back(rxData);
      if (rxValidL && rxReadyL) popCountL++;
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One SPI bit in mode 0: data set during SCK low, sampled on SCK rise.
   task automatic applyStimulus(input logic bitVal);
      spiMosi = bitVal;
      repeat (4) @(negedge clk);
      spiSck = 1'b1;
      repeat (4) @(negedge clk);
      spiSck = 1'b0;
   endtask

   // Sends the top nBits of value, bit 7 first on the wire.
   task automatic sendBits(input logic [7:0] value, input int nBits);
      for (int i = 0; i < nBits; i++) begin
         applyStimulus(value[7-i]);
      end
   endtask

   task automatic csLow();
      spiCsN = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic csHigh();
      repeat (8) @(negedge clk);
      spiCsN = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   int actBase, fsBase, feBase, valBase, popBase, popLBase;
   logic validDroppedL;

   initial begin
      totalChecks     = 0;
      badChecks       = 0;
      activityCount   = 0;
      frameStartCount = 0;
      frameEndCount   = 0;
      validCycles     = 0;
      popCountL       = 0;
      resetN     = 1'b0;
      spiSck     = 1'b0;
      spiCsN     = 1'b1;
      spiMosi    = 1'b0;
      rxReady    = 1'b1;
      rxReadyL   = 1'b1;
      overrunClr = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset rx_data",     {24'd0, rxData}, 32'h00);
      checkOutput("reset rx_valid",    {31'd0, rxValid}, 32'd0);
      checkOutput("reset frame_start", {31'd0, frameStart}, 32'd0);
      checkOutput("reset frame_end",   {31'd0, frameEnd}, 32'd0);
      checkOutput("reset activity",    {31'd0, activity}, 32'd0);
      checkOutput("reset overrun",     {31'd0, overrun}, 32'd0);
      resetN = 1'b1;
      repeat (6) @(negedge clk);

      // Single byte 0xA5, consumer always ready
      actBase = activityCount; fsBase = frameStartCount;
      feBase = frameEndCount; valBase = validCycles; popBase = popQ.size();
      csLow();
      sendBits(8'hA5, 8);
      csHigh();
      checkOutput("a5 frame_start count", frameStartCount - fsBase, 1);
      checkOutput("a5 activity count",    activityCount - actBase, 1);
      checkOutput("a5 pop count",         popQ.size() - popBase, 1);
      checkOutput("a5 data",              {24'd0, popQ[popBase]}, 32'hA5);
      checkOutput("a5 valid cycles",      validCycles - valBase, 1);
      checkOutput("a5 frame_end count",   frameEndCount - feBase, 1);

      // Back-to-back bytes
      actBase = activityCount; popBase = popQ.size();
      csLow();
      sendBits(8'h01, 8);
      sendBits(8'h80, 8);
      sendBits(8'hFF, 8);
      csHigh();
      checkOutput("b2b pop count",  popQ.size() - popBase, 3);
      checkOutput("b2b byte0",      {24'd0, popQ[popBase]},   32'h01);
      checkOutput("b2b byte1",      {24'd0, popQ[popBase+1]}, 32'h80);
      checkOutput("b2b byte2",      {24'd0, popQ[popBase+2]}, 32'hFF);
      checkOutput("b2b activity",   activityCount - actBase, 3);
      checkOutput("b2b overrun",    {31'd0, overrun}, 32'd0);

      // Overrun: consumer stalled across two bytes
      rxReady = 1'b0;
      actBase = activityCount; popBase = popQ.size();
      csLow();
      sendBits(8'h11, 8);
      sendBits(8'h22, 8);
      csHigh();
      checkOutput("ovr activity",  activityCount - actBase, 2);
      checkOutput("ovr rx_valid",  {31'd0, rxValid}, 32'd1);
      checkOutput("ovr rx_data",   {24'd0, rxData}, 32'h11);
      checkOutput("ovr overrun",   {31'd0, overrun}, 32'd1);
      rxReady = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("ovr pop count", popQ.size() - popBase, 1);
      checkOutput("ovr popped",    {24'd0, popQ[popBase]}, 32'h11);
      checkOutput("ovr valid after pop", {31'd0, rxValid}, 32'd0);
      checkOutput("ovr sticky",    {31'd0, overrun}, 32'd1);
      overrunClr = 1'b1;
      @(negedge clk);
      overrunClr = 1'b0;
      checkOutput("ovr cleared",   {31'd0, overrun}, 32'd0);

      // Partial byte abandoned, next frame must realign
      actBase = activityCount; feBase = frameEndCount; popBase = popQ.size();
      csLow();
      sendBits(8'b10110000, 5);
      csHigh();
      checkOutput("part frame_end", frameEndCount - feBase, 1);
      checkOutput("part activity",  activityCount - actBase, 0);
      checkOutput("part rx_valid",  {31'd0, rxValid}, 32'd0);
      csLow();
      sendBits(8'h3C, 8);
      csHigh();
      checkOutput("part next pops", popQ.size() - popBase, 1);
      checkOutput("part next data", {24'd0, popQ[popBase]}, 32'h3C);

      // Reset in the middle of a byte
      csLow();
      sendBits(8'hF0, 4);
      resetN = 1'b0;
      spiCsN = 1'b1;
      @(negedge clk);
      checkOutput("mid reset rx_data",  {24'd0, rxData}, 32'h00);
      checkOutput("mid reset rx_valid", {31'd0, rxValid}, 32'd0);
      checkOutput("mid reset activity", {31'd0, activity}, 32'd0);
      checkOutput("mid reset overrun",  {31'd0, overrun}, 32'd0);
      checkOutput("mid reset frame_st", {31'd0, frameStart}, 32'd0);
      checkOutput("mid reset frame_en", {31'd0, frameEnd}, 32'd0);
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      repeat (6) @(negedge clk);
      popBase = popQ.size();
      csLow();
      sendBits(8'hC3, 8);
      csHigh();
      checkOutput("post reset pops", popQ.size() - popBase, 1);
      checkOutput("post reset data", {24'd0, popQ[popBase]}, 32'hC3);

      // LSB-first instance: 1,0,0,0,0,0,0,0 on the wire is 0x01
      rxReadyL = 1'b0;
      csLow();
      sendBits(8'h80, 8);
      repeat (6) @(negedge clk);
      checkOutput("lsb rx_data",  {24'd0, rxDataL}, 32'h01);
      checkOutput("lsb rx_valid", {31'd0, rxValidL}, 32'd1);
      // Next byte 0,1,0,0,0,0,0,0 is 0x02. Its last SCK rise is seen two
      // clocks after the pin edge; ready is raised for exactly that cycle.
      popLBase = popCountL;
      validDroppedL = 1'b0;
      sendBits(8'h40, 7);
      spiMosi = 1'b0;
      repeat (4) @(negedge clk);
      spiSck = 1'b1;
      repeat (2) @(negedge clk);
      rxReadyL = 1'b1;
      @(negedge clk);
      rxReadyL = 1'b0;
      if (!rxValidL) validDroppedL = 1'b1;
      @(negedge clk);
      spiSck = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!rxValidL) validDroppedL = 1'b1;
         @(negedge clk);
      end
      checkOutput("lsb pop count",   popCountL - popLBase, 1);
      checkOutput("lsb valid held",  {31'd0, validDroppedL}, 32'd0);
      checkOutput("lsb new data",    {24'd0, rxDataL}, 32'h02);
      checkOutput("lsb overrun",     {31'd0, overrunL}, 32'd0);
      csHigh();

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

   // Hard stop so the bench always terminates.
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
